// File: rtl/uart_led_cmd_parser_pkg.sv
// Shared constants and types for the UART LED command parser.
package uart_led_cmd_parser_pkg;

  localparam logic [7:0] BYTE_HDR0 = 8'h55;
  localparam logic [7:0] BYTE_HDR1 = 8'hA5;
  localparam logic [7:0] BYTE_TAIL = 8'hF0;
  localparam int unsigned FRAME_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR2 = 3'd1,
    ST_TIME = 3'd2,
    ST_CTRL = 3'd3,
    ST_TAIL = 3'd4
  } parser_state_e;

  // True when the byte closes a frame with a usable step period.
  function automatic logic frame_accept(input logic [7:0] tail_byte,
                                        input logic [31:0] time_val);
    return (tail_byte == BYTE_TAIL) && (time_val != 32'd0);
  endfunction

endpackage

// File: rtl/uart_led_cmd_parser_if.sv
// Byte-in / pattern-out bundle between the UART receiver, parser and LED flasher.
interface uart_led_cmd_parser_if;

  logic [7:0]  Rx_Data;
  logic        Rx_Done;
  logic [7:0]  Ctrl;
  logic [31:0] Time;
  logic        Frame_Ok;
  logic        Frame_Err;
  logic        Busy;

  // Byte source side (receiver / testbench).
  modport master (
    output Rx_Data, Rx_Done,
    input  Ctrl, Time, Frame_Ok, Frame_Err, Busy
  );

  // Parser side.
  modport slave (
    input  Rx_Data, Rx_Done,
    output Ctrl, Time, Frame_Ok, Frame_Err, Busy
  );

endinterface

// File: rtl/uart_led_cmd_parser_timer.sv
// Inter-byte idle timer: flags expiry after TIMEOUT_CYC enabled cycles without a clear.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 500_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clr,
  input  logic En,
  output logic Expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear always wins over expiry, so a byte on the expiry cycle keeps the frame alive.
  assign Expire = En && !Clr && (cnt_q == LAST);

  // Next count: clear, restart after expiry, or advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (Clr || Expire) begin
      cnt_d = '0;
    end else if (En) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_led_cmd_parser.sv
// Parses 8-byte frames (55 A5 T3 T2 T1 T0 C F0) and atomically commits Ctrl/Time.
module uart_led_cmd_parser
  import uart_led_cmd_parser_pkg::*;
#(
  parameter logic [31:0] DEFAULT_TIME = 32'd25_000_000,
  parameter logic [7:0]  DEFAULT_CTRL = 8'h00,
  parameter int unsigned TIMEOUT_CYC  = 500_000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  uart_led_cmd_parser_if.slave  bus
);

  parser_state_e state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   tsh_q, tsh_d;
  logic [7:0]    csh_q, csh_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [31:0]   time_q, time_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          expire;
  logic          in_frame;

  assign in_frame = (state_q != ST_IDLE);

  cmd_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clr    (bus.Rx_Done || !in_frame),
    .En     (in_frame),
    .Expire (expire)
  );

  // Next-state and commit decode; bytes take priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tsh_d   = tsh_q;
    csh_d   = csh_q;
    ctrl_d  = ctrl_q;
    time_d  = time_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.Rx_Done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.Rx_Data == BYTE_HDR0) state_d = ST_HDR2;
        end
        ST_HDR2: begin
          if (bus.Rx_Data == BYTE_HDR1) begin
            state_d = ST_TIME;
            idx_d   = 2'd0;
          end else if (bus.Rx_Data != BYTE_HDR0) begin
            state_d = ST_IDLE;
          end
        end
        ST_TIME: begin
          tsh_d = {tsh_q[23:0], bus.Rx_Data};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_CTRL;
        end
        ST_CTRL: begin
          csh_d   = bus.Rx_Data;
          state_d = ST_TAIL;
        end
        ST_TAIL: begin
          state_d = ST_IDLE;
          if (frame_accept(bus.Rx_Data, tsh_q)) begin
            ctrl_d = csh_q;
            time_d = tsh_q;
            ok_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      tsh_q   <= 32'd0;
      csh_q   <= 8'd0;
      ctrl_q  <= DEFAULT_CTRL;
      time_q  <= DEFAULT_TIME;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tsh_q   <= tsh_d;
      csh_q   <= csh_d;
      ctrl_q  <= ctrl_d;
      time_q  <= time_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign bus.Ctrl      = ctrl_q;
  assign bus.Time      = time_q;
  assign bus.Frame_Ok  = ok_q;
  assign bus.Frame_Err = err_q;
  assign bus.Busy      = in_frame;

endmodule

// File: tb/tb_uart_led_cmd_parser.sv
// Randomized and directed bench for uart_led_cmd_parser against a byte-queue frame model.
module tb_uart_led_cmd_parser;

  localparam int unsigned T_CYC  = 20;
  localparam logic [31:0] D_TIME = 32'd25_000_000;
  localparam logic [7:0]  D_CTRL = 8'h00;

  logic Clk = 1'b0;
  logic Reset;

  uart_led_cmd_parser_if bus ();

  uart_led_cmd_parser #(
    .DEFAULT_TIME (D_TIME),
    .DEFAULT_CTRL (D_CTRL),
    .TIMEOUT_CYC  (T_CYC)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ok_seen = 0;
  int err_seen = 0;

  // Reference model: bytes of the frame in progress, committed values, idle cycle count.
  logic [7:0]  mbuf[$];
  logic [7:0]  m_ctrl;
  logic [31:0] m_time;
  int          m_idle;
  logic        e_ok, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbuf.delete();
    m_ctrl = D_CTRL;
    m_time = D_TIME;
    m_idle = 0;
    e_ok   = 1'b0;
    e_err  = 1'b0;
  endtask

  task automatic model_step(input logic done, input logic [7:0] b);
    logic [31:0] t;
    e_ok  = 1'b0;
    e_err = 1'b0;
    if (done) begin
      m_idle = 0;
      if (mbuf.size() == 0) begin
        if (b == 8'h55) mbuf.push_back(b);
      end else if (mbuf.size() == 1) begin
        if (b == 8'hA5) mbuf.push_back(b);
        else if (b != 8'h55) mbuf.delete();
      end else begin
        mbuf.push_back(b);
        if (mbuf.size() == 8) begin
          t = {mbuf[2], mbuf[3], mbuf[4], mbuf[5]};
          if (mbuf[7] == 8'hF0 && t != 0) begin
            m_ctrl = mbuf[6];
            m_time = t;
            e_ok   = 1'b1;
          end else begin
            e_err = 1'b1;
          end
          mbuf.delete();
        end
      end
    end else if (mbuf.size() > 0) begin
      m_idle++;
      if (m_idle == int'(T_CYC)) begin
        e_err  = 1'b1;
        mbuf.delete();
        m_idle = 0;
      end
    end
  endtask

  // One clock: present inputs, take the edge, advance the model, compare all outputs.
  task automatic cycle(input logic done, input logic [7:0] b);
    bus.Rx_Done = done;
    bus.Rx_Data = b;
    @(posedge Clk);
    #1;
    model_step(done, b);
    chk("frame_ok",  {31'd0, bus.Frame_Ok},  {31'd0, e_ok});
    chk("frame_err", {31'd0, bus.Frame_Err}, {31'd0, e_err});
    chk("busy",      {31'd0, bus.Busy},      {31'd0, mbuf.size() > 0});
    chk("ctrl",      {24'd0, bus.Ctrl},      {24'd0, m_ctrl});
    chk("time",      bus.Time,               m_time);
    if (bus.Frame_Ok)  ok_seen++;
    if (bus.Frame_Err) err_seen++;
    bus.Rx_Done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) begin
      cycle(1'b1, bytes[i]);
      idle(gap);
    end
  endtask

  int ok0, err0;
  logic [7:0] fr[$];
  logic [31:0] rt;

  initial begin
    Reset = 1'b1;
    bus.Rx_Done = 1'b0;
    bus.Rx_Data = 8'h00;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("rst_ctrl", {24'd0, bus.Ctrl}, 32'h0000_0000);
    chk("rst_time", bus.Time, 32'd25_000_000);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_pulses", {30'd0, bus.Frame_Ok, bus.Frame_Err}, 32'd0);
    idle(3);

    // Valid frame: Time=1000, Ctrl=5A, visible on the cycle after the trailer edge.
    ok0 = ok_seen;
    send('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h5A}, 0);
    cycle(1'b1, 8'hF0);
    chk("ok_on_trailer", {31'd0, bus.Frame_Ok}, 32'd1);
    chk("time_1000", bus.Time, 32'd1000);
    chk("ctrl_5a", {24'd0, bus.Ctrl}, 32'h5A);
    idle(2);
    chk("ok_count1", ok_seen - ok0, 1);

    // Time of zero is rejected.
    err0 = err_seen;
    send('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0}, 1);
    chk("zero_time_err", err_seen - err0, 1);
    chk("zero_time_keep", bus.Time, 32'd1000);

    // Bad trailer, then a header-resync frame.
    err0 = err_seen;
    send('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h0E}, 0);
    chk("bad_tail_err", err_seen - err0, 1);
    chk("bad_tail_ctrl", {24'd0, bus.Ctrl}, 32'h5A);
    ok0 = ok_seen;
    send('{8'h55, 8'h55, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h81, 8'hF0}, 2);
    chk("resync_ok", ok_seen - ok0, 1);
    chk("resync_time", bus.Time, 32'd16);
    chk("resync_ctrl", {24'd0, bus.Ctrl}, 32'h81);

    // Timeout mid-frame.
    err0 = err_seen;
    send('{8'h55, 8'hA5, 8'h00, 8'h00}, 0);
    idle(T_CYC + 2);
    chk("timeout_err", err_seen - err0, 1);
    chk("timeout_busy", {31'd0, bus.Busy}, 32'd0);

    // Byte exactly on the expiry cycle keeps the frame going.
    err0 = err_seen;
    ok0  = ok_seen;
    send('{8'h55, 8'hA5, 8'h00, 8'h00}, 0);
    idle(T_CYC - 1);
    send('{8'h00, 8'h07, 8'h3C, 8'hF0}, 0);
    idle(1);
    chk("expiry_byte_noerr", err_seen - err0, 0);
    chk("expiry_byte_ok", ok_seen - ok0, 1);
    chk("expiry_byte_time", bus.Time, 32'd7);

    // Timeout while waiting for the second header byte.
    err0 = err_seen;
    send('{8'h55}, 0);
    idle(T_CYC + 1);
    chk("hdr2_timeout", err_seen - err0, 1);

    // Reset after byte 5: outputs return to defaults, rest of frame ignored.
    send('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h03}, 0);
    Reset = 1'b1;
    #2;
    model_reset();
    chk("midrst_ctrl", {24'd0, bus.Ctrl}, 32'h00);
    chk("midrst_time", bus.Time, 32'd25_000_000);
    chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    ok0 = ok_seen;
    send('{8'hE8, 8'h5A, 8'hF0}, 0);
    idle(2);
    chk("midrst_no_commit", ok_seen - ok0, 0);

    // Randomized frames with assorted corruptions, gaps and noise.
    for (int f = 0; f < 60; f++) begin
      int kind;
      int gap;
      kind = $urandom_range(0, 7);
      rt = $urandom;
      if (kind == 2) rt = 32'd0;
      else if (rt == 0) rt = 32'd1;
      if ($urandom_range(0, 3) == 0) rt = rt & 32'h0000_00FF;
      fr.delete();
      if (kind == 6) fr.push_back(8'($urandom));
      fr.push_back(8'h55);
      if (kind == 4) fr.push_back(8'h55);
      fr.push_back(kind == 3 ? 8'($urandom_range(0, 255)) : 8'hA5);
      fr.push_back(rt[31:24]);
      fr.push_back(rt[23:16]);
      fr.push_back(rt[15:8]);
      fr.push_back(rt[7:0]);
      fr.push_back(8'($urandom));
      fr.push_back(kind == 1 ? 8'($urandom_range(0, 239)) : 8'hF0);
      if (kind == 5) begin
        fr = fr[0:$urandom_range(0, 6)];
      end
      gap = $urandom_range(0, 3);
      send(fr, gap);
      if (kind == 5) idle(T_CYC + $urandom_range(0, 3));
      else idle($urandom_range(0, 2));
    end

    idle(T_CYC + 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
